sync_fifo_rr_drain: RTL and testbench
=====================================

# sync_fifo_rr_drain

Round-robin drain controller that shares one output stream between NUM_REQ requesters, each owning a `sync_fifo` instance. It watches each FIFO's `empty` and `fifo_counter` and issues that FIFO's `rden`. It captures the FIFO `dout` one cycle after `rden` and presents it on a valid/ready master port, in bursts tagged with the source index. It sits between the per-channel FIFOs and the shared downstream link/DMA writer.

## Interface
- NUM_REQ, 4: number of requester FIFOs (≥2)
- WIDTH, 32: FIFO data width
- CNT_W, 5: width of each FIFO `fifo_counter` (CLOG2(DEPTH)+1)
- MAX_BURST, 8: maximum beats drained per grant (≥1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_empty  in  NUM_REQ  `empty` of each FIFO, bit i = requester i
- fifo_count  in  NUM_REQ*CNT_W  `fifo_counter` of each FIFO, slice i
- fifo_dout  in  NUM_REQ*WIDTH  `dout` of each FIFO, slice i
- fifo_rden  out  NUM_REQ  `rden` to each FIFO, one-hot or zero
- m_valid  out  1  output beat valid
- m_data  out  WIDTH  output beat data
- m_src  out  max(1,CLOG2(NUM_REQ))  requester index of beat
- m_last  out  1  final beat of current burst
- m_ready  in  1  downstream accept
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: requests are `~fifo_empty`. If any request is set, grant the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ. On grant, register the grant index and set `burst_len = min(fifo_count[g], MAX_BURST)`. Set `rr_ptr = (g+1) mod NUM_REQ`, clear `issued`, and go to READ. With no request, stay in IDLE.
- READ: assert `fifo_rden[g]` when all three hold:
  - `issued < burst_len`;
  - `fifo_empty[g]==0`;
  - `occ + inflight - (m_valid & m_ready) < 2`, where `occ` is the output buffer count (0..2) and `inflight` is an rden issued last cycle.
- Each rden increments `issued`. When the rden with `issued == burst_len-1` is issued, go to DRAIN.
- Capture: in the cycle after an rden, push `fifo_dout[g]` into a 2-entry output FIFO. The entry is tagged with `g` and with last = (this is the burst_len-th beat).
- The output buffer head drives m_valid/m_data/m_src/m_last. The head pops when `m_valid & m_ready`.
- DRAIN: when the beat with m_last is accepted, go to IDLE. The next arbitration happens in the following cycle.
- Only this block reads the FIFOs, so `fifo_count` latched at grant bounds the burst. Writes arriving during a burst do not extend it.
- fifo_rden is never asserted to a non-granted FIFO or to an empty FIFO.
- Arithmetic: `issued` and `burst_len` are CLOG2(MAX_BURST+1) bits wide. The min() compares the full CNT_W count.

## Timing
- Reset values: fifo_rden=0, m_valid=0, m_data=0, m_src=0, m_last=0, busy=0. State=IDLE, rr_ptr=0, occ=0, inflight=0. The buffer contents are discarded.
- Latency: request seen in IDLE at cycle T → grant at T+1 (state READ, fifo_rden high in T+1) → FIFO dout valid at T+2 → captured at end of T+2 → m_valid at T+3.
- Throughput: with m_ready held high, one beat per cycle within a burst.
- Turnaround between bursts, with m_ready high: the last beat is accepted at cycle L, IDLE is at L+1, and the next rden is at L+2.
- Backpressure: m_valid, m_data, m_src and m_last hold stable while `m_valid & ~m_ready`. No beat is dropped or duplicated. At most 2 beats are buffered, so at most one rden can be outstanding beyond the buffer.
- Simultaneous push and pop in one cycle: occ is unchanged and the buffer order is preserved.
- Reset asserted mid-burst: all outputs are forced to reset values asynchronously. The burst is abandoned. The FIFOs are reset by the same system reset.

## Test plan
- Single requester: FIFO0 holds A,B,C; all others empty; m_ready=1 → fifo_rden[0] high for 3 cycles from T+1; beats A,B,C with m_src=0 at T+3..T+5; m_last only on C; busy drops after C.
- Burst cap, MAX_BURST=8: FIFO1 holds 12 entries → first burst is 8 beats ending in m_last. After one IDLE cycle, FIFO1 is re-granted (only requester) for the remaining 4 beats.
- Round-robin wrap, NUM_REQ=4: FIFO3 and FIFO0 each hold 1 entry; rr_ptr forced to 3 by a prior grant of FIFO2 → grant order is 3 then 0; m_src sequence 3,0; rr_ptr ends at 1.
- Backpressure: FIFO2 holds 5 entries; m_ready toggles 1,0,0,1,0,1,... → exactly 5 beats in FIFO order. Data stays stable while stalled. At most 2 rden are issued ahead of acceptance, and the FIFO never underflows.
- Fairness: all 4 FIFOs are kept non-empty → grants follow 0,1,2,3,0,...; each burst is min(count, 8) beats.
- Reset mid-burst: rst pulses high during the 3rd beat of a 6-beat burst → m_valid and fifo_rden go low immediately; after release, state is IDLE with rr_ptr=0.

Source files
------------

// File: rtl/sync_fifo_rr_drain.sv
// sync_fifo_rr_drain: round-robin drain controller. Watches NUM_REQ sync_fifo
// instances, grants one at a time, reads up to MAX_BURST beats from the granted
// FIFO and streams them out through a 2-entry skid buffer tagged with the
// source index and an end-of-burst marker.
//
// Handshake: a beat transfers on a rising edge where m_valid && m_ready. Once
// m_valid is high, m_data/m_src/m_last hold until that transfer happens.
module sync_fifo_rr_drain #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int CNT_W     = 5,
  parameter int MAX_BURST = 8,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BL_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       fifo_empty,
  input  logic [NUM_REQ*CNT_W-1:0] fifo_count,
  input  logic [NUM_REQ*WIDTH-1:0] fifo_dout,
  output logic [NUM_REQ-1:0]       fifo_rden,
  output logic                     m_valid,
  output logic [WIDTH-1:0]         m_data,
  output logic [SRC_W-1:0]         m_src,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     busy,
  output logic [1:0]               dbg_state,
  output logic [SRC_W-1:0]         dbg_rr_ptr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Grant bookkeeping
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [BL_W-1:0]  burst_len_q, burst_len_d;
  logic [BL_W-1:0]  issued_q, issued_d;

  // Read issued last cycle; its data appears on fifo_dout this cycle
  logic inflight_q, inflight_d;
  logic inflight_last_q, inflight_last_d;

  // Two-entry output buffer
  logic [1:0][WIDTH-1:0] buf_data_q, buf_data_d;
  logic [1:0][SRC_W-1:0] buf_src_q, buf_src_d;
  logic [1:0]            buf_last_q, buf_last_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            occ_q, occ_d;

  // Unpacked views of the flat per-FIFO buses
  logic [CNT_W-1:0] cnt_arr  [NUM_REQ];
  logic [WIDTH-1:0] dout_arr [NUM_REQ];

  // Arbiter results
  logic             req_any;
  logic [SRC_W-1:0] arb_idx;
  logic [BL_W-1:0]  arb_len;
  logic [SRC_W-1:0] arb_next_ptr;

  // Read-issue and buffer control
  logic rden_go;
  logic last_rd;
  logic pop;
  logic push;
  logic head_last;

  // Slice the flat FIFO buses into per-requester arrays
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_arr[i]  = fifo_count[i*CNT_W +: CNT_W];
      dout_arr[i] = fifo_dout[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search starting at rr_ptr, plus burst length for the winner
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] idx_w;
    logic [CNT_W-1:0] cnt_g;
    req_any      = 1'b0;
    arb_idx      = '0;
    idx          = 0;
    idx_w        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(rr_ptr_q) + k) % NUM_REQ;
      idx_w = SRC_W'(idx);
      if (!req_any && !fifo_empty[idx_w]) begin
        req_any = 1'b1;
        arb_idx = idx_w;
      end
    end
    // Full-width compare so a large count never aliases into a short burst.
    // A zero count on a non-empty FIFO is clamped to one beat so the burst
    // can always terminate.
    cnt_g = cnt_arr[arb_idx];
    if (cnt_g == '0) begin
      arb_len = BL_W'(1);
    end else if (32'(cnt_g) >= 32'(MAX_BURST)) begin
      arb_len = BL_W'(MAX_BURST);
    end else begin
      arb_len = BL_W'(cnt_g);
    end
    if (arb_idx == SRC_W'(NUM_REQ - 1)) begin
      arb_next_ptr = '0;
    end else begin
      arb_next_ptr = arb_idx + SRC_W'(1);
    end
  end

  // Read issue: stay within the burst, never read an empty FIFO, and never
  // commit more beats than the output buffer can absorb
  always_comb begin
    logic [2:0] committed;
    logic [2:0] limit;
    pop       = (occ_q != 2'd0) && m_ready;
    push      = inflight_q;
    head_last = buf_last_q[rd_ptr_q];
    committed = {1'b0, occ_q} + {2'b00, inflight_q};
    limit     = 3'd2 + {2'b00, pop};
    rden_go   = (state_q == ST_READ) &&
                (issued_q < burst_len_q) &&
                !fifo_empty[grant_q] &&
                (committed < limit);
    last_rd   = rden_go && (issued_q == (burst_len_q - BL_W'(1)));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_any) state_d = ST_READ;
      ST_READ:  if (last_rd) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && head_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: read strobe, head of the output buffer, status
  always_comb begin
    fifo_rden = '0;
    if (rden_go) begin
      fifo_rden[grant_q] = 1'b1;
    end
    m_valid    = (occ_q != 2'd0);
    m_data     = buf_data_q[rd_ptr_q];
    m_src      = buf_src_q[rd_ptr_q];
    m_last     = buf_last_q[rd_ptr_q];
    busy       = (state_q != ST_IDLE);
    dbg_state  = state_q;
    dbg_rr_ptr = rr_ptr_q;
  end

  // Grant and burst counters
  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    burst_len_d     = burst_len_q;
    issued_d        = issued_q;
    inflight_d      = rden_go;
    inflight_last_d = last_rd;
    if ((state_q == ST_IDLE) && req_any) begin
      grant_d     = arb_idx;
      burst_len_d = arb_len;
      rr_ptr_d    = arb_next_ptr;
      issued_d    = '0;
    end else if (rden_go) begin
      issued_d = issued_q + BL_W'(1);
    end
  end

  // Output buffer: capture the FIFO data one cycle after its read strobe;
  // a simultaneous push and pop keeps occupancy and order intact
  always_comb begin
    buf_data_d = buf_data_q;
    buf_src_d  = buf_src_q;
    buf_last_d = buf_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    if (push) begin
      buf_data_d[wr_ptr_q] = dout_arr[grant_q];
      buf_src_d[wr_ptr_q]  = grant_q;
      buf_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  // Datapath registers; reset abandons any burst and clears the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      burst_len_q     <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_data_q      <= '0;
      buf_src_q       <= '0;
      buf_last_q      <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      burst_len_q     <= burst_len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      buf_data_q      <= buf_data_d;
      buf_src_q       <= buf_src_d;
      buf_last_q      <= buf_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      occ_q           <= occ_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_rr_drain.sv
// Directed bench for sync_fifo_rr_drain with a behavioural sync_fifo model per
// requester and an ordered expected-beat queue.
`timescale 1ns/1ps
module tb_sync_fifo_rr_drain;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int CW = 5;
  localparam int MB = 8;
  localparam int SW = 2;
  localparam int BW = SW + 1 + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NR-1:0]         fempty = '1;
  logic [NR-1:0][CW-1:0] fcnt   = '0;
  logic [NR-1:0][W-1:0]  fdout  = '0;
  logic [NR-1:0]         fifo_rden;
  logic                  m_valid;
  logic [W-1:0]          m_data;
  logic [SW-1:0]         m_src;
  logic                  m_last;
  logic                  m_ready = 1'b1;
  logic                  busy;
  logic [1:0]            dbg_state;
  logic [SW-1:0]         dbg_rr_ptr;

  sync_fifo_rr_drain #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(CW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fempty),
    .fifo_count (fcnt),
    .fifo_dout  (fdout),
    .fifo_rden  (fifo_rden),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_src      (m_src),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [W-1:0]    mem [NR][64];
  int              head [NR];
  int              tail [NR];
  logic [SW+W-1:0] pend_q [$];
  logic [NR-1:0]   rden_smp = '0;
  int              cyc = 0;

  initial begin
    for (int c = 0; c < NR; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
  end

  // Writes land on the edge after they are queued; reads update dout on the
  // edge that sees rden, like a registered-output sync_fifo
  always @(posedge clk) begin
    logic [SW+W-1:0] pe;
    int              c2;
    cyc++;
    if (rst) begin
      for (int c = 0; c < NR; c++) begin
        head[c] = 0;
        tail[c] = 0;
      end
      pend_q.delete();
    end else begin
      for (int c = 0; c < NR; c++) begin
        if (rden_smp[c]) begin
          check_eq("no_underflow", 64'(tail[c] > head[c]), 64'd1);
          if (tail[c] > head[c]) begin
            fdout[c] <= mem[c][6'(head[c])];
            head[c]++;
          end
        end
      end
      while (pend_q.size() > 0) begin
        pe = pend_q.pop_front();
        c2 = int'(pe[SW+W-1:W]);
        mem[c2][6'(tail[c2])] = pe[W-1:0];
        tail[c2]++;
      end
    end
    for (int c = 0; c < NR; c++) begin
      fcnt[c]   <= CW'(tail[c] - head[c]);
      fempty[c] <= (tail[c] == head[c]);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [BW-1:0] exp_q [$];
  int            acc_cyc [$];
  int            rden_cnt [NR];
  int            rden_total = 0;
  int            acc_total  = 0;
  int            max_ahead  = 0;
  int            first_rden_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat  = '0;

  initial for (int c = 0; c < NR; c++) rden_cnt[c] = 0;

  always @(negedge clk) begin
    logic [BW-1:0] beat;
    beat = {m_src, m_last, m_data};
    if (rst) begin
      rden_smp   = '0;
      prev_stall = 1'b0;
    end else begin
      rden_smp = fifo_rden;
      check_eq("rden_onehot0", 64'($onehot0(fifo_rden)), 64'd1);
      for (int c = 0; c < NR; c++) if (fifo_rden[c]) rden_cnt[c]++;
      if ((fifo_rden != '0) && (first_rden_cyc < 0)) first_rden_cyc = cyc;
      rden_total += $countones(fifo_rden);
      if (prev_stall) check_eq("hold_stable", 64'({m_valid, beat}), 64'({1'b1, prev_beat}));
      if (m_valid && m_ready) begin
        acc_total++;
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) check_eq("extra_beat", 64'(beat), 64'd0 - 64'd1);
        else check_eq("beat", 64'(beat), 64'(exp_q.pop_front()));
      end
      if (rden_total - acc_total > max_ahead) max_ahead = rden_total - acc_total;
      prev_stall = m_valid && !m_ready;
      prev_beat  = beat;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk_data(input int tid, input int ch, input int k);
    return {8'(tid), 8'(ch), 16'(k)};
  endfunction

  task automatic push_fifo(input int ch, input int tid, input int n);
    for (int k = 0; k < n; k++) pend_q.push_back({SW'(ch), mk_data(tid, ch, k)});
  endtask

  task automatic exp_burst(input int ch, input int tid, input int start, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({SW'(ch), (k == n - 1), mk_data(tid, ch, start + k)});
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    first_rden_cyc = -1;
    max_ahead      = 0;
    for (int c = 0; c < NR; c++) rden_cnt[c] = 0;
  endtask

  function automatic int acc_at(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) tick();
    while ((exp_q.size() != 0 || busy || m_valid) && n < 500) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(n < 500), 64'd1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int            c0;
    int            base;
    int            n;
    logic [5:0]    bp_pat;
    bp_pat = 6'b101001;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    check_eq("rst_rden",   64'(fifo_rden), 64'd0);
    check_eq("rst_valid",  64'(m_valid), 64'd0);
    check_eq("rst_data",   64'(m_data), 64'd0);
    check_eq("rst_src",    64'(m_src), 64'd0);
    check_eq("rst_last",   64'(m_last), 64'd0);
    check_eq("rst_busy",   64'(busy), 64'd0);
    check_eq("rst_state",  64'(dbg_state), 64'd0);
    check_eq("rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
    rst = 1'b0;
    tick();

    // Single requester: A,B,C from FIFO0, latency and back-to-back beats
    clear_logs();
    c0 = cyc;
    push_fifo(0, 1, 3);
    exp_burst(0, 1, 0, 3);
    wait_idle("t1_done");
    check_eq("t1_first_rden_cyc", 64'(first_rden_cyc), 64'(c0 + 2));
    check_eq("t1_beat0_cyc",      64'(acc_at(0)), 64'(c0 + 4));
    check_eq("t1_beat2_cyc",      64'(acc_at(2)), 64'(c0 + 6));
    check_eq("t1_rden_cnt0",      64'(rden_cnt[0]), 64'd3);
    check_eq("t1_busy_low",       64'(busy), 64'd0);
    check_eq("t1_rr_ptr",         64'(dbg_rr_ptr), 64'd1);

    // Burst cap: 12 entries in FIFO1 -> 8 then 4, one idle cycle between
    clear_logs();
    push_fifo(1, 3, 12);
    exp_burst(1, 3, 0, 8);
    exp_burst(1, 3, 8, 4);
    wait_idle("t2_done");
    check_eq("t2_turnaround", 64'(acc_at(8) - acc_at(7)), 64'd4);
    check_eq("t2_rden_cnt1",  64'(rden_cnt[1]), 64'd12);
    check_eq("t2_rr_ptr",     64'(dbg_rr_ptr), 64'd2);

    // Round-robin wrap: grant FIFO2 first, then FIFO3 and FIFO0 together
    clear_logs();
    push_fifo(2, 4, 1);
    exp_burst(2, 4, 0, 1);
    wait_idle("t3a_done");
    check_eq("t3_rr_ptr_mid", 64'(dbg_rr_ptr), 64'd3);
    push_fifo(3, 5, 1);
    push_fifo(0, 5, 1);
    exp_burst(3, 5, 0, 1);
    exp_burst(0, 5, 0, 1);
    wait_idle("t3b_done");
    check_eq("t3_rr_ptr_end", 64'(dbg_rr_ptr), 64'd1);

    // Backpressure: 5 beats from FIFO2 with m_ready toggling
    clear_logs();
    base = acc_total;
    push_fifo(2, 6, 5);
    exp_burst(2, 6, 0, 5);
    for (int i = 0; i < 30; i++) begin
      m_ready = bp_pat[i % 6];
      tick();
    end
    m_ready = 1'b1;
    wait_idle("t4_done");
    check_eq("t4_beats",     64'(acc_total - base), 64'd5);
    check_eq("t4_rden_cnt2", 64'(rden_cnt[2]), 64'd5);
    check_eq("t4_ahead_le2", 64'(max_ahead <= 2), 64'd1);
    check_eq("t4_rr_ptr",    64'(dbg_rr_ptr), 64'd3);

    // Reset mid-burst: 6-beat burst from FIFO1, reset while beat 3 is presented
    clear_logs();
    base = acc_total;
    push_fifo(1, 7, 6);
    exp_burst(1, 7, 0, 6);
    n = 0;
    while (acc_total < base + 2 && n < 100) begin
      tick();
      n++;
    end
    check_eq("t5_reach_beat3", 64'(n < 100), 64'd1);
    check_eq("t5_valid_pre",   64'(m_valid), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_eq("t5_valid_rst", 64'(m_valid), 64'd0);
    check_eq("t5_rden_rst",  64'(fifo_rden), 64'd0);
    check_eq("t5_busy_rst",  64'(busy), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("t5_state_idle", 64'(dbg_state), 64'd0);
    check_eq("t5_rr_ptr",     64'(dbg_rr_ptr), 64'd0);
    check_eq("t5_valid_post", 64'(m_valid), 64'd0);

    // Fairness: all four FIFOs loaded, grants rotate 0,1,2,3,0,2
    clear_logs();
    base = acc_total;
    push_fifo(0, 8, 10);
    push_fifo(1, 8, 3);
    push_fifo(2, 8, 9);
    push_fifo(3, 8, 2);
    exp_burst(0, 8, 0, 8);
    exp_burst(1, 8, 0, 3);
    exp_burst(2, 8, 0, 8);
    exp_burst(3, 8, 0, 2);
    exp_burst(0, 8, 8, 2);
    exp_burst(2, 8, 8, 1);
    wait_idle("t6_done");
    check_eq("t6_beats",  64'(acc_total - base), 64'd24);
    check_eq("t6_rr_ptr", 64'(dbg_rr_ptr), 64'd3);
    check_eq("t6_empty",  64'(fempty), 64'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls outright
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1);
  end

endmodule
